// File: rtl/pc_stream_source.sv
// ---------------------------------------------------------------------------
// pc_stream_source
//
// PIO-programmed, length-bounded data source for the PCIe to-PC FIFO port.
// Each run emits exactly COUNT 64-bit words, either popped from the from-PC
// FIFO (loopback) or produced by an internal pattern generator (counter or
// LFSR). Downstream almost-full backpressure stalls issue; status is
// readable over PIO.
//
// Register map (word offsets from BASE_ADDR, which must be 4-aligned):
//   +0 CTRL   W: [1:0] mode (0 idle, 1 loopback, 2 counter, 3 LFSR),
//                [2] start pulse, [3] abort pulse (abort wins over start)
//             R: stored mode in [1:0]
//   +1 COUNT  W/R: [31:0] word count
//   +2 SEED   W/R: 64-bit pattern seed
//   +3 STATUS R: [0] busy, [1] done (sticky), [3:2] active mode,
//                [63:32] words remaining
//
// Ports:
//   clock, rst_n                 single clock, async active-low reset
//   pio_write_valid/read_valid   PIO strobes
//   pio_address                  13-bit PIO word address
//   pio_write_data               64-bit PIO write data
//   pio_read_data/_valid         registered one-cycle read response
//   fifo_from_pc_data/_empty     first-word-fall-through source FIFO
//   fifo_from_pc_read            combinational pop (loopback issue only)
//   fifo_to_pc_data/_write       registered sink FIFO write port
//   fifo_to_pc_almost_full       sink backpressure, sampled at issue
//   busy                         engine not idle
//
// Configuration macro: PC_STREAM_LFSR_EN
//   defined   -> mode 3 runs the LFSR generator
//   undefined -> no LFSR logic; mode 3 generates the counter pattern
//                (STATUS still reports mode 3)
// ---------------------------------------------------------------------------
module pc_stream_source #(
   parameter logic [12:0] BASE_ADDR = 13'h0100
) (
   input  logic        clock,
   input  logic        rst_n,
   input  logic        pio_write_valid,
   input  logic        pio_read_valid,
   input  logic [12:0] pio_address,
   input  logic [63:0] pio_write_data,
   output logic [63:0] pio_read_data,
   output logic        pio_read_data_valid,
   input  logic [63:0] fifo_from_pc_data,
   input  logic        fifo_from_pc_empty,
   output logic        fifo_from_pc_read,
   output logic [63:0] fifo_to_pc_data,
   output logic        fifo_to_pc_write,
   input  logic        fifo_to_pc_almost_full,
   output logic        busy
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      MODE_OFF  = 2'd0,
      MODE_LOOP = 2'd1,
      MODE_CNT  = 2'd2,
      MODE_LFSR = 2'd3
   } mode_t;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_t      state_q,     state_d;
   mode_t       mode_q,      mode_d;       // programmed mode (CTRL)
   logic [31:0] count_q,     count_d;      // programmed COUNT
   logic [63:0] seed_q,      seed_d;       // programmed SEED
   mode_t       wmode_q,     wmode_d;      // working copy, latched at start
   logic [31:0] remaining_q, remaining_d;  // working count
   logic [63:0] pattern_q,   pattern_d;    // next generator word
   logic        done_q,      done_d;
   logic [63:0] out_data_q,  out_data_d;
   logic        out_write_q, out_write_d;
   logic [63:0] rd_data_q,   rd_data_d;
   logic        rd_valid_q,  rd_valid_d;

   // ------------------------------------------------------------------
   // PIO decode
   // ------------------------------------------------------------------
   logic       addr_hit;
   logic [1:0] reg_off;
   logic       wr_hit;
   logic       wr_ctrl;
   logic       start_req;
   logic       abort_req;
   mode_t      start_mode;

   assign addr_hit   = (pio_address[12:2] == BASE_ADDR[12:2]);
   assign reg_off    = pio_address[1:0];
   assign wr_hit     = pio_write_valid && addr_hit;
   assign wr_ctrl    = wr_hit && (reg_off == 2'd0);
   assign abort_req  = wr_ctrl && pio_write_data[3];
   assign start_req  = wr_ctrl && pio_write_data[2] && !pio_write_data[3];
   assign start_mode = mode_t'(pio_write_data[1:0]);

   // ------------------------------------------------------------------
   // Pattern generator
   // ------------------------------------------------------------------
   logic [63:0] seed_init;   // first word of a generator run
   logic [63:0] pattern_nx;  // successor of pattern_q for the active mode

`ifdef PC_STREAM_LFSR_EN
   always_comb begin
      seed_init  = seed_q;
      pattern_nx = pattern_q + 64'd1;
      // The all-zero state is a lock-up state of the LFSR.
      if (start_mode == MODE_LFSR && seed_q == '0) begin
         seed_init = 64'd1;
      end
      if (wmode_q == MODE_LFSR) begin
         pattern_nx = {pattern_q[62:0],
                       pattern_q[63] ^ pattern_q[62] ^ pattern_q[60] ^ pattern_q[59]};
      end
   end
`else
   always_comb begin
      seed_init  = seed_q;
      pattern_nx = pattern_q + 64'd1;
   end
`endif

   // ------------------------------------------------------------------
   // Issue condition
   // ------------------------------------------------------------------
   logic issue;

   // An abort write suppresses issue (and so any pop) in its own cycle.
   assign issue = (state_q == ST_RUN) && !abort_req &&
                  (remaining_q != '0) && !fifo_to_pc_almost_full &&
                  ((wmode_q != MODE_LOOP) || !fifo_from_pc_empty);

   assign fifo_from_pc_read = issue && (wmode_q == MODE_LOOP);

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      count_d     = count_q;
      seed_d      = seed_q;
      wmode_d     = wmode_q;
      remaining_d = remaining_q;
      pattern_d   = pattern_q;
      done_d      = done_q;
      out_data_d  = out_data_q;
      out_write_d = 1'b0;
      rd_valid_d  = 1'b0;
      rd_data_d   = '0;

      // Register writes are accepted in every state.
      if (wr_hit) begin
         case (reg_off)
            2'd0:    mode_d  = start_mode;
            2'd1:    count_d = pio_write_data[31:0];
            2'd2:    seed_d  = pio_write_data;
            default: ;
         endcase
      end

      case (state_q)
         ST_IDLE: begin
            if (start_req && start_mode != MODE_OFF) begin
               state_d     = ST_RUN;
               wmode_d     = start_mode;
               remaining_d = count_q;
               pattern_d   = seed_init;
               done_d      = 1'b0;
            end
         end

         ST_RUN: begin
            if (abort_req) begin
               state_d = ST_IDLE;
            end else begin
               if (issue) begin
                  out_write_d = 1'b1;
                  out_data_d  = (wmode_q == MODE_LOOP) ? fifo_from_pc_data : pattern_q;
                  pattern_d   = pattern_nx;
                  remaining_d = remaining_q - 32'd1;
               end
               // Leaves together with the last issue; COUNT=0 leaves at once.
               if (remaining_d == '0) begin
                  state_d = ST_FLUSH;
               end
            end
         end

         ST_FLUSH: begin
            state_d = ST_IDLE;
            if (!abort_req) begin
               done_d = 1'b1;
            end
         end

         default: state_d = ST_IDLE;
      endcase

      // Read response reflects register contents at the request cycle.
      if (pio_read_valid && addr_hit) begin
         rd_valid_d = 1'b1;
         case (reg_off)
            2'd0:    rd_data_d = {62'd0, mode_q};
            2'd1:    rd_data_d = {32'd0, count_q};
            2'd2:    rd_data_d = seed_q;
            default: rd_data_d = {remaining_q, 28'd0, wmode_q, done_q, (state_q != ST_IDLE)};
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         mode_q      <= MODE_OFF;
         count_q     <= '0;
         seed_q      <= '0;
         wmode_q     <= MODE_OFF;
         remaining_q <= '0;
         pattern_q   <= '0;
         done_q      <= 1'b0;
         out_data_q  <= '0;
         out_write_q <= 1'b0;
         rd_data_q   <= '0;
         rd_valid_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         count_q     <= count_d;
         seed_q      <= seed_d;
         wmode_q     <= wmode_d;
         remaining_q <= remaining_d;
         pattern_q   <= pattern_d;
         done_q      <= done_d;
         out_data_q  <= out_data_d;
         out_write_q <= out_write_d;
         rd_data_q   <= rd_data_d;
         rd_valid_q  <= rd_valid_d;
      end
   end

   assign fifo_to_pc_data     = out_data_q;
   assign fifo_to_pc_write    = out_write_q;
   assign pio_read_data       = rd_data_q;
   assign pio_read_data_valid = rd_valid_q;
   assign busy                = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pc_stream_source.sv
// ---------------------------------------------------------------------------
// Testbench for pc_stream_source: register table plus stream scenarios with
// a scoreboard of expected to-PC words and a model of the from-PC FIFO.
// ---------------------------------------------------------------------------
module tb_pc_stream_source;

   localparam logic [12:0] BASE   = 13'h0100;
   localparam logic [12:0] A_CTRL = BASE + 13'd0;
   localparam logic [12:0] A_CNT  = BASE + 13'd1;
   localparam logic [12:0] A_SEED = BASE + 13'd2;
   localparam logic [12:0] A_STAT = BASE + 13'd3;

   logic        clock = 1'b0;
   logic        rst_n;
   logic        pio_write_valid;
   logic        pio_read_valid;
   logic [12:0] pio_address;
   logic [63:0] pio_write_data;
   logic [63:0] pio_read_data;
   logic        pio_read_data_valid;
   logic [63:0] fifo_from_pc_data;
   logic        fifo_from_pc_empty;
   logic        fifo_from_pc_read;
   logic [63:0] fifo_to_pc_data;
   logic        fifo_to_pc_write;
   logic        fifo_to_pc_almost_full;
   logic        busy;

   pc_stream_source #(.BASE_ADDR(BASE)) dut (
      .clock                  (clock),
      .rst_n                  (rst_n),
      .pio_write_valid        (pio_write_valid),
      .pio_read_valid         (pio_read_valid),
      .pio_address            (pio_address),
      .pio_write_data         (pio_write_data),
      .pio_read_data          (pio_read_data),
      .pio_read_data_valid    (pio_read_data_valid),
      .fifo_from_pc_data      (fifo_from_pc_data),
      .fifo_from_pc_empty     (fifo_from_pc_empty),
      .fifo_from_pc_read      (fifo_from_pc_read),
      .fifo_to_pc_data        (fifo_to_pc_data),
      .fifo_to_pc_write       (fifo_to_pc_write),
      .fifo_to_pc_almost_full (fifo_to_pc_almost_full),
      .busy                   (busy)
   );

   always #5 clock = ~clock;

   int          tests = 0;
   int          fails = 0;
   int          writes = 0;
   int          pops = 0;
   logic [63:0] sb[$];        // expected to-PC words
   logic [63:0] from_pc[$];   // from-PC FIFO contents

   typedef struct {
      logic        wr;
      logic [12:0] addr;
      logic [63:0] wdata;
      logic        exp_valid;
      logic [63:0] exp_data;
   } vec_t;

   vec_t vecs[20];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic fifo_pins();
      fifo_from_pc_empty = (from_pc.size() == 0);
      fifo_from_pc_data  = (from_pc.size() == 0) ? 64'd0 : from_pc[0];
   endtask

   // One clock: starts and ends at a negedge. Inputs are driven by the caller
   // at the negedge; pop request is sampled just before the posedge.
   task automatic tick();
      logic pop_now;
      #4;
      pop_now = fifo_from_pc_read;
      @(negedge clock);
      if (pop_now) begin
         pops++;
         if (from_pc.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL pop_empty: got pop with FIFO empty, expected no pop");
         end else begin
            void'(from_pc.pop_front());
         end
         fifo_pins();
      end
      if (fifo_to_pc_write) begin
         writes++;
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_write: got data %h, expected no write", fifo_to_pc_data);
         end else begin
            check("stream_data", fifo_to_pc_data, sb.pop_front());
         end
      end
   endtask

   task automatic pio_write(input logic [12:0] addr, input logic [63:0] data);
      pio_write_valid = 1'b1;
      pio_address     = addr;
      pio_write_data  = data;
      tick();
      pio_write_valid = 1'b0;
      pio_write_data  = '0;
   endtask

   task automatic pio_read(input string name, input logic [12:0] addr,
                           input logic exp_valid, input logic [63:0] exp_data);
      pio_read_valid = 1'b1;
      pio_address    = addr;
      tick();
      pio_read_valid = 1'b0;
      check({name, "_valid"}, pio_read_data_valid, exp_valid);
      check({name, "_data"}, pio_read_data, exp_data);
   endtask

   task automatic wait_idle(input string name, input int limit);
      int n = 0;
      while (busy && n < limit) begin
         tick();
         n++;
      end
      if (busy) begin
         tests++;
         fails++;
         $display("FAIL %s_timeout: got busy=1 after %0d cycles, expected idle", name, limit);
      end
   endtask

   task automatic wait_writes(input string name, input int target, input int limit);
      int n = 0;
      while (writes < target && n < limit) begin
         tick();
         n++;
      end
      if (writes < target) begin
         tests++;
         fails++;
         $display("FAIL %s_timeout: got %0d writes, expected %0d", name, writes, target);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before 200000");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] w0;
      logic [63:0] exp_stat;

      rst_n = 1'b0;
      pio_write_valid = 1'b0;
      pio_read_valid = 1'b0;
      pio_address = '0;
      pio_write_data = '0;
      fifo_to_pc_almost_full = 1'b0;
      fifo_pins();
      repeat (2) @(negedge clock);

      // Reset state
      check("rst_write", fifo_to_pc_write, 0);
      check("rst_data", fifo_to_pc_data, 0);
      check("rst_pop", fifo_from_pc_read, 0);
      check("rst_rdata", pio_read_data, 0);
      check("rst_rvalid", pio_read_data_valid, 0);
      check("rst_busy", busy, 0);
      rst_n = 1'b1;
      @(negedge clock);

      // Register table
      vecs[0]  = '{1'b0, A_CTRL, 64'd0, 1'b1, 64'd0};
      vecs[1]  = '{1'b0, A_CNT,  64'd0, 1'b1, 64'd0};
      vecs[2]  = '{1'b0, A_SEED, 64'd0, 1'b1, 64'd0};
      vecs[3]  = '{1'b0, A_STAT, 64'd0, 1'b1, 64'd0};
      vecs[4]  = '{1'b1, A_CNT,  64'hFFFF_0000_8765_4321, 1'b0, 64'd0};
      vecs[5]  = '{1'b0, A_CNT,  64'd0, 1'b1, 64'h0000_0000_8765_4321};
      vecs[6]  = '{1'b1, A_SEED, 64'hDEAD_BEEF_0123_4567, 1'b0, 64'd0};
      vecs[7]  = '{1'b0, A_SEED, 64'd0, 1'b1, 64'hDEAD_BEEF_0123_4567};
      vecs[8]  = '{1'b1, A_CTRL, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 64'd0}; // start+abort
      vecs[9]  = '{1'b0, A_CTRL, 64'd0, 1'b1, 64'd2};
      vecs[10] = '{1'b0, A_STAT, 64'd0, 1'b1, 64'd0};
      vecs[11] = '{1'b1, A_CTRL, 64'h4, 1'b0, 64'd0};                  // mode 0 start
      vecs[12] = '{1'b0, A_STAT, 64'd0, 1'b1, 64'd0};
      vecs[13] = '{1'b0, A_CTRL, 64'd0, 1'b1, 64'd0};
      vecs[14] = '{1'b1, 13'h0104, 64'h3, 1'b0, 64'd0};
      vecs[15] = '{1'b0, A_CTRL, 64'd0, 1'b1, 64'd0};
      vecs[16] = '{1'b0, 13'h0104, 64'd0, 1'b0, 64'd0};
      vecs[17] = '{1'b0, 13'h00FF, 64'd0, 1'b0, 64'd0};
      vecs[18] = '{1'b1, 13'h0105, 64'h55, 1'b0, 64'd0};
      vecs[19] = '{1'b0, A_CNT,  64'd0, 1'b1, 64'h0000_0000_8765_4321};

      for (int i = 0; i < 20; i++) begin
         if (vecs[i].wr) begin
            pio_write(vecs[i].addr, vecs[i].wdata);
         end else begin
            pio_read($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp_valid, vecs[i].exp_data);
         end
         check($sformatf("vec%0d_busy", i), busy, 0);
      end

      // Counter, SEED=0x10, COUNT=4
      sb.delete();
      writes = 0;
      pio_write(A_CNT, 64'd4);
      pio_write(A_SEED, 64'h10);
      for (int i = 0; i < 4; i++) sb.push_back(64'h10 + 64'(i));
      pio_write(A_CTRL, 64'h6);
      check("cnt_busy_t1", busy, 1);
      check("cnt_nowrite_t1", fifo_to_pc_write, 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("cnt_consec%0d", i), fifo_to_pc_write, 1);
      end
      tick();
      check("cnt_busy_drop", busy, 0);
      pio_read("cnt_status", A_STAT, 1'b1, 64'hA);
      check("cnt_writes", writes, 4);
      check("cnt_sb_empty", sb.size(), 0);

      // Loopback, COUNT=3, FIFO preloaded with A..E
      sb.delete();
      writes = 0;
      pops = 0;
      for (int i = 0; i < 5; i++) from_pc.push_back(64'hA000_0000_0000_0000 + 64'(i));
      fifo_pins();
      for (int i = 0; i < 3; i++) sb.push_back(64'hA000_0000_0000_0000 + 64'(i));
      pio_write(A_CNT, 64'd3);
      pio_write(A_CTRL, 64'h5);
      wait_idle("loop", 30);
      check("loop_writes", writes, 3);
      check("loop_pops", pops, 3);
      check("loop_left", from_pc.size(), 2);
      check("loop_left_head", fifo_from_pc_data, 64'hA000_0000_0000_0003);
      check("loop_pop_idle", fifo_from_pc_read, 0);
      pio_read("loop_status", A_STAT, 1'b1, 64'h6);
      check("loop_sb_empty", sb.size(), 0);
      from_pc.delete();
      fifo_pins();

      // Counter COUNT=8 with backpressure after word 2 for 10 cycles
      sb.delete();
      writes = 0;
      pio_write(A_CNT, 64'd8);
      pio_write(A_SEED, 64'h100);
      for (int i = 0; i < 8; i++) sb.push_back(64'h100 + 64'(i));
      pio_write(A_CTRL, 64'h6);
      wait_writes("bp_first2", 2, 20);
      fifo_to_pc_almost_full = 1'b1;
      w0 = 64'(writes);
      repeat (10) tick();
      check("bp_extra_le1", ((64'(writes) - w0) <= 64'd1), 1);
      check("bp_busy_held", busy, 1);
      fifo_to_pc_almost_full = 1'b0;
      wait_idle("bp", 30);
      check("bp_writes", writes, 8);
      check("bp_sb_empty", sb.size(), 0);

      // COUNT=0 start in counter mode
      sb.delete();
      writes = 0;
      pio_write(A_CNT, 64'd0);
      pio_write(A_CTRL, 64'h6);
      check("zero_run", busy, 1);
      tick();
      check("zero_flush", busy, 1);
      tick();
      check("zero_idle", busy, 0);
      pio_read("zero_status", A_STAT, 1'b1, 64'hA);
      check("zero_writes", writes, 0);

      // Abort after 3 of COUNT=100, with an ignored restart mid-run
      sb.delete();
      writes = 0;
      pio_write(A_CNT, 64'd100);
      pio_write(A_SEED, 64'h55);
      for (int i = 0; i < 100; i++) sb.push_back(64'h55 + 64'(i));
      pio_write(A_CTRL, 64'h6);
      wait_writes("abort_first", 1, 20);
      pio_write(A_CTRL, 64'h6);
      wait_writes("abort_three", 3, 20);
      pio_write(A_CTRL, 64'hA);
      tick();
      tick();
      check("abort_idle", busy, 0);
      check("abort_write_bound", (writes <= 4), 1);
      exp_stat = {32'(100 - writes), 32'h8};
      pio_read("abort_status", A_STAT, 1'b1, exp_stat);
      sb.delete();

      // Mode 3, SEED=0
      sb.delete();
      writes = 0;
      pio_write(A_CNT, 64'd2);
      pio_write(A_SEED, 64'd0);
`ifdef PC_STREAM_LFSR_EN
      sb.push_back(64'd1);
      sb.push_back(64'd2);
`else
      sb.push_back(64'd0);
      sb.push_back(64'd1);
`endif
      pio_write(A_CTRL, 64'h7);
      wait_idle("mode3", 20);
      check("mode3_writes", writes, 2);
      check("mode3_sb_empty", sb.size(), 0);
      pio_read("mode3_status", A_STAT, 1'b1, 64'hE);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
